// File: rtl/counter_cmd_pkg.sv
// Shared types and defaults for the cursor-counter command front end.
// Command encoding order doubles as the press priority (clr > up > down > load).
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCKOUT
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_UP,
    CMD_DOWN,
    CMD_LOAD
  } cmd_t;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 500000;
  localparam int DEF_REPEAT_RATE     = 100000;

  function automatic cmd_t pick_cmd(input logic clr, input logic up,
                                    input logic down, input logic load);
    cmd_t c;
    c = CMD_NONE;
    if (clr)       c = CMD_CLR;
    else if (up)   c = CMD_UP;
    else if (down) c = CMD_DOWN;
    else if (load) c = CMD_LOAD;
    return c;
  endfunction

  function automatic logic is_repeating(input cmd_t c);
    return (c == CMD_UP) || (c == CMD_DOWN);
  endfunction

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// Raw user inputs in, one-cycle counter commands out.
// slave is the command stage, master is whoever owns the buttons.
interface counter_cmd_ctrl_if
  import counter_cmd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             btn_up;
  logic             btn_down;
  logic             btn_load;
  logic             btn_clr;
  logic [WIDTH-1:0] sw_load;
  logic             clr_out;
  logic             inc_out;
  logic             dec_out;
  logic             par_out;
  logic [WIDTH-1:0] load_out;

  modport master (
    output btn_up, btn_down, btn_load, btn_clr, sw_load,
    input  clr_out, inc_out, dec_out, par_out, load_out
  );

  modport slave (
    input  btn_up, btn_down, btn_load, btn_clr, sw_load,
    output clr_out, inc_out, dec_out, par_out, load_out
  );
endinterface

// File: rtl/btn_debounce.sv
// 2-flop synchronizer plus stable-count debouncer for one raw button.
// clean follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic din,
  output logic clean
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == clean) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        clean <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/counter_cmd_ctrl.sv
// Turns bouncy buttons into one-hot single-cycle counter commands with up/down auto-repeat.
// Press-to-pulse latency is 3+DEBOUNCE_CYCLES edges; all outputs registered.
module counter_cmd_ctrl
  import counter_cmd_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input logic              CLK,
  input logic              CLR_N,
  counter_cmd_ctrl_if.slave bus
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(CNT_MAX);

  logic             c_clr, c_up, c_down, c_load;
  logic [WIDTH-1:0] sw_s1, sw_s2;
  state_t           state, state_nxt;
  cmd_t             act, act_nxt, pulse, sel;
  logic [RW-1:0]    rcnt, rcnt_nxt;
  logic             act_lvl, any_btn;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr  (.CLK(CLK), .CLR_N(CLR_N), .din(bus.btn_clr),  .clean(c_clr));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up   (.CLK(CLK), .CLR_N(CLR_N), .din(bus.btn_up),   .clean(c_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (.CLK(CLK), .CLR_N(CLR_N), .din(bus.btn_down), .clean(c_down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (.CLK(CLK), .CLR_N(CLR_N), .din(bus.btn_load), .clean(c_load));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= bus.sw_load;
      sw_s2 <= sw_s1;
    end
  end

  assign any_btn = c_clr | c_up | c_down | c_load;
  assign sel     = pick_cmd(c_clr, c_up, c_down, c_load);

  always_comb begin
    act_lvl = 1'b0;
    case (act)
      CMD_UP:   act_lvl = c_up;
      CMD_DOWN: act_lvl = c_down;
      default:  act_lvl = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    act_nxt   = act;
    rcnt_nxt  = rcnt;
    pulse     = CMD_NONE;
    case (state)
      ST_IDLE: begin
        if (sel != CMD_NONE) begin
          pulse   = sel;
          act_nxt = sel;
          if (is_repeating(sel)) begin
            state_nxt = ST_DELAY;
            rcnt_nxt  = RW'(REPEAT_DELAY - 1);
          end else begin
            state_nxt = ST_LOCKOUT;
          end
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // Release is checked first so the release cycle never fires.
        if (!act_lvl) begin
          state_nxt = ST_LOCKOUT;
        end else if (rcnt == '0) begin
          pulse     = act;
          rcnt_nxt  = RW'(REPEAT_RATE - 1);
          state_nxt = ST_REPEAT;
        end else begin
          rcnt_nxt = rcnt - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (!any_btn) begin
          state_nxt = ST_IDLE;
          act_nxt   = CMD_NONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state        <= ST_IDLE;
      act          <= CMD_NONE;
      rcnt         <= '0;
      bus.clr_out  <= 1'b0;
      bus.inc_out  <= 1'b0;
      bus.dec_out  <= 1'b0;
      bus.par_out  <= 1'b0;
      bus.load_out <= '0;
    end else begin
      state       <= state_nxt;
      act         <= act_nxt;
      rcnt        <= rcnt_nxt;
      bus.clr_out <= (pulse == CMD_CLR);
      bus.inc_out <= (pulse == CMD_UP);
      bus.dec_out <= (pulse == CMD_DOWN);
      bus.par_out <= (pulse == CMD_LOAD);
      if (pulse == CMD_LOAD) bus.load_out <= sw_s2;
    end
  end
endmodule
